// File: rtl/sbtm_pkg.sv
// Shared constants, state encoding and entry packing for the SBTM table loader.
// Entry layout is {a0, a1}, identical to what the lookup datapath reads.
package sbtm_pkg;

   localparam int ADDR_W = 8;
   localparam int A0_W   = 18;
   localparam int A1_W   = 12;
   localparam int WORD_W = 16;
   localparam int ENT_W  = A0_W + A1_W;
   localparam int HI_W   = ENT_W - WORD_W;

   typedef enum logic [2:0] {
      IDLE,
      LO,
      HI,
      WR,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_RSVD = 2'b01;
   localparam logic [1:0] ERR_CSUM = 2'b10;

   function automatic logic [ENT_W-1:0] assemble_entry(
      input logic [WORD_W-1:0] w0,
      input logic [WORD_W-1:0] w1
   );
      return {w1[HI_W-1:0], w0};
   endfunction

endpackage

// File: rtl/sbtm_csum16.sv
// 16-bit wraparound running sum of accepted stream words.
// clr has priority over en so a restart never folds in a stray word.
module sbtm_csum16
   import sbtm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [WORD_W-1:0] data,
   output logic [WORD_W-1:0] sum
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (en) begin
         sum <= sum + data;
      end
   end

endmodule

// File: rtl/sbtm_table_loader.sv
// Streams 256 two-word entries into the external table RAM, then checks
// a trailing checksum word before raising tbl_valid.
module sbtm_table_loader
   import sbtm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              tbl_we,
   output logic [ADDR_W-1:0] tbl_addr,
   output logic [ENT_W-1:0]  tbl_wdata,
   output logic              tbl_valid,
   output logic              busy,
   output logic [1:0]        err
);

   state_t            state;
   state_t            nxt;
   logic              rdy;
   logic              xfer;
   logic              w1_bad;
   logic              last;
   logic              csum_ok;
   logic              csum_en;
   logic [WORD_W-1:0] w0;
   logic [WORD_W-1:0] sum;

   // start wins over a coincident transfer: the word stays on the bus
   assign in_ready = rdy & ~start;
   assign xfer     = in_valid & in_ready;
   assign w1_bad   = in_data[WORD_W-1:HI_W] != '0;
   assign last     = tbl_addr == '1;
   assign csum_ok  = in_data == sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt     = state;
      rdy     = 1'b0;
      tbl_we  = 1'b0;
      busy    = 1'b0;
      csum_en = 1'b0;
      unique case (state)
         LO: begin
            rdy     = 1'b1;
            busy    = 1'b1;
            csum_en = xfer;
            if (xfer) nxt = HI;
         end
         HI: begin
            rdy     = 1'b1;
            busy    = 1'b1;
            csum_en = xfer;
            if (xfer) nxt = w1_bad ? ERR : WR;
         end
         WR: begin
            tbl_we = 1'b1;
            busy   = 1'b1;
            nxt    = last ? CHK : LO;
         end
         CHK: begin
            rdy  = 1'b1;
            busy = 1'b1;
            if (xfer) nxt = csum_ok ? DONE : ERR;
         end
         default: begin
            nxt = state;
         end
      endcase
      if (start) nxt = LO;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w0        <= '0;
         tbl_addr  <= '0;
         tbl_wdata <= '0;
         tbl_valid <= 1'b0;
         err       <= ERR_NONE;
      end else if (start) begin
         tbl_addr  <= '0;
         tbl_valid <= 1'b0;
         err       <= ERR_NONE;
      end else begin
         if (state == LO && xfer) begin
            w0 <= in_data;
         end
         if (state == HI && xfer) begin
            if (w1_bad) err <= ERR_RSVD;
            else tbl_wdata <= assemble_entry(w0, in_data);
         end
         if (state == WR && !last) begin
            tbl_addr <= tbl_addr + 1'b1;
         end
         if (state == CHK && xfer) begin
            if (csum_ok) tbl_valid <= 1'b1;
            else err <= ERR_CSUM;
         end
      end
   end

   sbtm_csum16 u_csum (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (start),
      .en   (csum_en),
      .data (in_data),
      .sum  (sum)
   );

endmodule

// File: tb/tb_sbtm_table_loader.sv
// Table-driven load scenarios checked against an expected-write queue
// and checksum computed directly from the entry table.
module tb_sbtm_table_loader;
   import sbtm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        tbl_we;
   logic [7:0]  tbl_addr;
   logic [29:0] tbl_wdata;
   logic        tbl_valid;
   logic        busy;
   logic [1:0]  err;

   sbtm_table_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .tbl_we   (tbl_we),
      .tbl_addr (tbl_addr),
      .tbl_wdata(tbl_wdata),
      .tbl_valid(tbl_valid),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;

   typedef struct {
      int          a;
      logic [29:0] d;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         got;
   logic [29:0] ent [256];

   typedef struct {
      int         duty;
      int         bad;
      int         coff;
      int         abort_lo;
      int         rst_at;
      bit         rnd;
      logic [1:0] exp_err;
      bit         exp_valid;
      int         exp_wr;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tbl_we === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we: got addr %0d expected no write",
                     tbl_addr);
         end else begin
            got = exp_q.pop_front();
            chk("we_addr", 32'(tbl_addr), 32'(got.a));
            chk("we_data", 32'(tbl_wdata), 32'(got.d));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_word(input logic [15:0] w, input int duty,
                            input bit chk_we, output bit ok);
      int  n;
      bit  done;
      n    = 0;
      done = 0;
      ok   = 1;
      while (!done) begin
         in_valid = ($urandom_range(99) < duty);
         in_data  = in_valid ? w : 16'($urandom);
         #1;
         if (in_valid && in_ready) done = 1;
         @(negedge clk);
         n++;
         if (!done && n > 300) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got no accept expected accept");
            ok   = 0;
            done = 1;
         end
      end
      in_valid = 1'b0;
      if (ok && chk_we) chk("we_latency", 32'(tbl_we), 32'd1);
   endtask

   task automatic pulse_start();
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      wr_cnt   = 0;
      #1;
      chk("start_blocks_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_addr", 32'(tbl_addr), 32'd0);
      chk("start_err", 32'(err), 32'd0);
      chk("start_valid", 32'(tbl_valid), 32'd0);
   endtask

   task automatic run_load(input int duty, input int bad, input int coff,
                           input int abort_lo, input int rst_at);
      logic [15:0] sum;
      logic [15:0] w0;
      logic [15:0] w1;
      bit          ok;
      sum = '0;
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         w0 = ent[i][15:0];
         w1 = {2'b00, ent[i][29:16]};
         if (i == bad) w1 = 16'h4001;
         send_word(w0, duty, 0, ok);
         if (!ok) return;
         sum += w0;
         if (i == abort_lo) return;
         sum += w1;
         if (i == bad) begin
            send_word(w1, duty, 0, ok);
            return;
         end
         exp_q.push_back('{i, ent[i]});
         send_word(w1, duty, 1, ok);
         if (!ok) return;
         if (i == rst_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_we", 32'(tbl_we), 32'd0);
            chk("arst_busy", 32'(busy), 32'd0);
            chk("arst_ready", 32'(in_ready), 32'd0);
            chk("arst_addr", 32'(tbl_addr), 32'd0);
            chk("arst_wdata", 32'(tbl_wdata), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
      end
      send_word(sum + 16'(coff), duty, 0, ok);
   endtask

   initial begin
      vecs[0] = '{100, -1, 0,      -1,  -1, 0, ERR_NONE, 1, 256};
      vecs[1] = '{100,  5, 0,      -1,  -1, 0, ERR_RSVD, 0, 5};
      vecs[2] = '{100, -1, 1,      -1,  -1, 0, ERR_CSUM, 0, 256};
      vecs[3] = '{100, -1, 0,      100, -1, 0, ERR_NONE, 1, 256};
      vecs[4] = '{30,  -1, 0,      -1,  -1, 0, ERR_NONE, 1, 256};
      vecs[5] = '{100, -1, 0,      -1,  42, 0, ERR_NONE, 1, 256};
      vecs[6] = '{60,  -1, 0,      -1,  -1, 1, ERR_NONE, 1, 256};
      vecs[7] = '{80,  -1, 'h1234, -1,  -1, 1, ERR_CSUM, 0, 256};

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_we", 32'(tbl_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(tbl_valid), 32'd0);
      chk("rst_addr", 32'(tbl_addr), 32'd0);
      chk("rst_wdata", 32'(tbl_wdata), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 256; i++) begin
            if (vecs[k].rnd) ent[i] = 30'($urandom);
            else ent[i] = {18'(i * 3), 12'(i)};
         end
         if (vecs[k].abort_lo >= 0)
            run_load(100, -1, 0, vecs[k].abort_lo, -1);
         if (vecs[k].rst_at >= 0)
            run_load(100, -1, 0, -1, vecs[k].rst_at);
         run_load(vecs[k].duty, vecs[k].bad, vecs[k].coff, -1, -1);
         chk($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].exp_err));
         chk($sformatf("v%0d_valid", k), 32'(tbl_valid),
             32'(vecs[k].exp_valid));
         chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
         chk($sformatf("v%0d_ready", k), 32'(in_ready), 32'd0);
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d_wr_cnt", k), 32'(wr_cnt),
             32'(vecs[k].exp_wr));
         chk($sformatf("v%0d_pending", k), 32'(exp_q.size()), 32'd0);
         chk($sformatf("v%0d_hold_err", k), 32'(err),
             32'(vecs[k].exp_err));
         chk($sformatf("v%0d_hold_valid", k), 32'(tbl_valid),
             32'(vecs[k].exp_valid));
         exp_q.delete();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
